// File: rtl/bp_common_pkg.sv
// Shared SV39 constants and typedefs for the page-table walker.
package bp_common_pkg;

    localparam int unsigned sv39_vaddr_width_gp       = 39;
    localparam int unsigned sv39_paddr_width_gp       = 56;
    localparam int unsigned sv39_pte_width_gp         = 64;
    localparam int unsigned sv39_page_offset_width_gp = 12;
    localparam int unsigned sv39_levels_gp            = 3;
    localparam int unsigned sv39_vpn_width_gp         = 27;
    localparam int unsigned sv39_ppn_width_gp         = 44;
    localparam int unsigned sv39_vpn_seg_width_gp     = 9;

    typedef enum logic [1:0] {
        E_IDLE,
        E_SEND,
        E_WAIT,
        E_DONE
    } bp_ptw_state_e;

    typedef struct packed {
        logic [9:0]                   reserved;
        logic [sv39_ppn_width_gp-1:0] ppn;
        logic [1:0]                   rsw;
        logic                         d;
        logic                         a;
        logic                         g;
        logic                         u;
        logic                         x;
        logic                         w;
        logic                         r;
        logic                         v;
    } bp_sv39_pte_s;

    typedef struct packed {
        logic [sv39_vpn_width_gp-1:0] vpn;
        logic [sv39_ppn_width_gp-1:0] ppn;
        logic [1:0]                   level;
        logic [7:0]                   flags;
        logic                         fault;
    } bp_ptw_fill_s;

    // PPN bits that a superpage leaf at the given level takes from the VPN.
    function automatic logic [sv39_ppn_width_gp-1:0] superpage_mask(input logic [1:0] level);
        logic [sv39_ppn_width_gp-1:0] mask;
        case (level)
            2'd1:    mask = {{(sv39_ppn_width_gp-sv39_vpn_seg_width_gp){1'b0}},
                             {sv39_vpn_seg_width_gp{1'b1}}};
            2'd2:    mask = {{(sv39_ppn_width_gp-2*sv39_vpn_seg_width_gp){1'b0}},
                             {(2*sv39_vpn_seg_width_gp){1'b1}}};
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/bp_sv39_pte_decode.sv
// Combinational SV39 PTE classifier: leaf/pointer, fault, composed leaf PPN.
module bp_sv39_pte_decode
    import bp_common_pkg::*;
(
    input  bp_sv39_pte_s                 pte_i,
    input  logic [1:0]                   level_i,
    input  logic [sv39_vpn_width_gp-1:0] vpn_i,
    output logic                         is_leaf_o,
    output logic                         fault_o,
    output logic [sv39_ppn_width_gp-1:0] ppn_o
);

    logic [sv39_ppn_width_gp-1:0] mask;
    logic [sv39_ppn_width_gp-1:0] vpn_ext;
    logic                         unused_pte_bits;

    assign mask            = superpage_mask(level_i);
    assign vpn_ext         = {{(sv39_ppn_width_gp-sv39_vpn_width_gp){1'b0}}, vpn_i};
    assign unused_pte_bits = ^{pte_i.reserved, pte_i.rsw, pte_i.d, pte_i.g, pte_i.u};

    // Classify the PTE; a faulting PTE always yields a zero PPN.
    always_comb begin
        is_leaf_o = pte_i.r | pte_i.x;
        fault_o   = 1'b0;
        ppn_o     = '0;
        if (!pte_i.v || (!pte_i.r && pte_i.w)) begin
            fault_o = 1'b1;
        end else if (is_leaf_o) begin
            if (((pte_i.ppn & mask) != '0) || !pte_i.a) begin
                fault_o = 1'b1;
            end else begin
                ppn_o = (pte_i.ppn & ~mask) | (vpn_ext & mask);
            end
        end else if (level_i == 2'd0) begin
            fault_o = 1'b1;
        end
    end

endmodule

// File: rtl/bp_sv39_ptw.sv
// SV39 hardware page-table walker: one outstanding PTE read per level.
module bp_sv39_ptw
    import bp_common_pkg::*;
#(
    parameter int unsigned vaddr_width_p       = 39,
    parameter int unsigned paddr_width_p       = 56,
    parameter int unsigned pte_width_p         = 64,
    parameter int unsigned page_offset_width_p = 12,
    parameter int unsigned levels_p            = 3,
    localparam int unsigned vpn_width_lp       = vaddr_width_p - page_offset_width_p,
    localparam int unsigned ppn_width_lp       = paddr_width_p - page_offset_width_p,
    localparam int unsigned vpn_seg_width_lp   = vpn_width_lp / levels_p
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [ppn_width_lp-1:0]  satp_ppn_i,
    input  logic                     miss_v_i,
    input  logic [vpn_width_lp-1:0]  miss_vpn_i,
    output logic                     miss_ready_o,
    output logic                     mem_req_v_o,
    output logic [paddr_width_p-1:0] mem_req_addr_o,
    input  logic                     mem_req_ready_i,
    input  logic                     mem_resp_v_i,
    input  logic [pte_width_p-1:0]   mem_resp_data_i,
    output logic                     fill_v_o,
    output logic [vpn_width_lp-1:0]  fill_vpn_o,
    output logic [ppn_width_lp-1:0]  fill_ppn_o,
    output logic [1:0]               fill_level_o,
    output logic [7:0]               fill_flags_o,
    output logic                     fill_fault_o,
    input  logic                     fill_yumi_i
);

    localparam logic [1:0] root_level_lp = 2'(levels_p - 1);

    bp_ptw_state_e               state_q, state_d;
    logic [vpn_width_lp-1:0]     vpn_q, vpn_d;
    logic [ppn_width_lp-1:0]     base_ppn_q, base_ppn_d;
    logic [1:0]                  level_q, level_d;
    bp_ptw_fill_s                fill_q, fill_d;

    bp_sv39_pte_s                pte;
    logic [vpn_seg_width_lp-1:0] vpn_seg;
    logic                        dec_is_leaf;
    logic                        dec_fault;
    logic [ppn_width_lp-1:0]     dec_ppn;

    assign pte = bp_sv39_pte_s'(mem_resp_data_i);

    bp_sv39_pte_decode pte_decode (
        .pte_i     (pte),
        .level_i   (level_q),
        .vpn_i     (vpn_q),
        .is_leaf_o (dec_is_leaf),
        .fault_o   (dec_fault),
        .ppn_o     (dec_ppn)
    );

    // Select the VPN segment indexing the table at the current level.
    always_comb begin
        case (level_q)
            2'd0:    vpn_seg = vpn_q[vpn_seg_width_lp-1:0];
            2'd1:    vpn_seg = vpn_q[2*vpn_seg_width_lp-1:vpn_seg_width_lp];
            2'd2:    vpn_seg = vpn_q[3*vpn_seg_width_lp-1:2*vpn_seg_width_lp];
            default: vpn_seg = '0;
        endcase
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d    = state_q;
        vpn_d      = vpn_q;
        base_ppn_d = base_ppn_q;
        level_d    = level_q;
        fill_d     = fill_q;

        miss_ready_o   = (state_q == E_IDLE);
        mem_req_v_o    = (state_q == E_SEND);
        fill_v_o       = (state_q == E_DONE);
        mem_req_addr_o = {base_ppn_q, {page_offset_width_p{1'b0}}}
                       + paddr_width_p'({vpn_seg, 3'b000});

        case (state_q)
            E_IDLE: begin
                if (miss_v_i) begin
                    vpn_d      = miss_vpn_i;
                    base_ppn_d = satp_ppn_i;
                    level_d    = root_level_lp;
                    state_d    = E_SEND;
                end
            end
            E_SEND: begin
                if (mem_req_ready_i) begin
                    state_d = E_WAIT;
                end
            end
            E_WAIT: begin
                if (mem_resp_v_i) begin
                    if (dec_fault || dec_is_leaf) begin
                        fill_d.vpn   = vpn_q;
                        fill_d.ppn   = dec_ppn;
                        fill_d.level = level_q;
                        fill_d.flags = mem_resp_data_i[7:0];
                        fill_d.fault = dec_fault;
                        state_d      = E_DONE;
                    end else begin
                        base_ppn_d = pte.ppn;
                        level_d    = level_q - 2'd1;
                        state_d    = E_SEND;
                    end
                end
            end
            E_DONE: begin
                if (fill_yumi_i) begin
                    state_d = E_IDLE;
                end
            end
            default: state_d = E_IDLE;
        endcase

        fill_vpn_o   = fill_q.vpn;
        fill_ppn_o   = fill_q.ppn;
        fill_level_o = fill_q.level;
        fill_flags_o = fill_q.flags;
        fill_fault_o = fill_q.fault;
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= E_IDLE;
            vpn_q      <= '0;
            base_ppn_q <= '0;
            level_q    <= '0;
            fill_q     <= '0;
        end else begin
            state_q    <= state_d;
            vpn_q      <= vpn_d;
            base_ppn_q <= base_ppn_d;
            level_q    <= level_d;
            fill_q     <= fill_d;
        end
    end

endmodule

// File: tb/tb_bp_sv39_ptw.sv
// Directed scoreboard bench for the SV39 page-table walker.
module tb_bp_sv39_ptw;
    import bp_common_pkg::*;

    logic        clk;
    logic        reset_i;
    logic [43:0] satp_ppn_i;
    logic        miss_v_i;
    logic [26:0] miss_vpn_i;
    logic        miss_ready_o;
    logic        mem_req_v_o;
    logic [55:0] mem_req_addr_o;
    logic        mem_req_ready_i;
    logic        mem_resp_v_i;
    logic [63:0] mem_resp_data_i;
    logic        fill_v_o;
    logic [26:0] fill_vpn_o;
    logic [43:0] fill_ppn_o;
    logic [1:0]  fill_level_o;
    logic [7:0]  fill_flags_o;
    logic        fill_fault_o;
    logic        fill_yumi_i;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [55:0]  exp_addr_q[$];
    bp_ptw_fill_s exp_fill_q[$];

    bp_sv39_ptw #(
        .vaddr_width_p       (39),
        .paddr_width_p       (56),
        .pte_width_p         (64),
        .page_offset_width_p (12),
        .levels_p            (3)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .satp_ppn_i      (satp_ppn_i),
        .miss_v_i        (miss_v_i),
        .miss_vpn_i      (miss_vpn_i),
        .miss_ready_o    (miss_ready_o),
        .mem_req_v_o     (mem_req_v_o),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_resp_v_i    (mem_resp_v_i),
        .mem_resp_data_i (mem_resp_data_i),
        .fill_v_o        (fill_v_o),
        .fill_vpn_o      (fill_vpn_o),
        .fill_ppn_o      (fill_ppn_o),
        .fill_level_o    (fill_level_o),
        .fill_flags_o    (fill_flags_o),
        .fill_fault_o    (fill_fault_o),
        .fill_yumi_i     (fill_yumi_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic recover();
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        mem_req_ready_i = 1'b0;
        mem_resp_v_i    = 1'b0;
        fill_yumi_i     = 1'b0;
        miss_v_i        = 1'b0;
        exp_addr_q.delete();
        exp_fill_q.delete();
        @(negedge clk);
    endtask

    task automatic expect_fill(input logic [26:0] vpn, input logic [43:0] ppn,
                               input logic [1:0] level, input logic [7:0] flags,
                               input logic fault);
        bp_ptw_fill_s f;
        f.vpn = vpn; f.ppn = ppn; f.level = level; f.flags = flags; f.fault = fault;
        exp_fill_q.push_back(f);
    endtask

    task automatic present_miss(input logic [43:0] satp, input logic [26:0] vpn);
        check("miss_ready_idle", miss_ready_o, 1);
        miss_v_i   = 1'b1;
        satp_ppn_i = satp;
        miss_vpn_i = vpn;
        @(negedge clk);
        miss_v_i   = 1'b0;
        satp_ppn_i = 44'hABCDE;
        miss_vpn_i = '0;
        check("miss_accepted", miss_ready_o, 0);
    endtask

    // Wait for a request, check it against the scoreboard, stall, then answer.
    task automatic serve(input logic [63:0] pte, input int unsigned stall, input logic junk);
        int unsigned n = 0;
        logic [55:0] exp;
        while (mem_req_v_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (mem_req_v_o !== 1'b1) begin
            check("req_timeout", mem_req_v_o, 1);
            recover();
            return;
        end
        if (exp_addr_q.size() == 0) begin
            check("req_unexpected", mem_req_v_o, 0);
            recover();
            return;
        end
        exp = exp_addr_q.pop_front();
        check("req_addr", mem_req_addr_o, exp);
        for (int unsigned i = 0; i < stall; i++) begin
            @(negedge clk);
            check("req_hold_v", mem_req_v_o, 1);
            check("req_hold_addr", mem_req_addr_o, exp);
        end
        mem_req_ready_i = 1'b1;
        if (junk) begin
            mem_resp_v_i    = 1'b1;
            mem_resp_data_i = 64'h100000CF;
        end
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        mem_resp_v_i    = 1'b0;
        check("req_single", mem_req_v_o, 0);
        mem_resp_v_i    = 1'b1;
        mem_resp_data_i = pte;
        @(negedge clk);
        mem_resp_v_i    = 1'b0;
        mem_resp_data_i = '0;
    endtask

    task automatic check_fill(input string tag, input bp_ptw_fill_s exp);
        check({tag, "_v"},     fill_v_o, 1);
        check({tag, "_vpn"},   fill_vpn_o, exp.vpn);
        check({tag, "_ppn"},   fill_ppn_o, exp.ppn);
        check({tag, "_level"}, fill_level_o, exp.level);
        check({tag, "_flags"}, fill_flags_o, exp.flags);
        check({tag, "_fault"}, fill_fault_o, exp.fault);
        check({tag, "_miss_ready"}, miss_ready_o, 0);
    endtask

    // Wait for the fill, compare against the scoreboard, hold, then consume.
    task automatic finish_walk(input int unsigned hold);
        int unsigned n = 0;
        logic extra = 1'b0;
        bp_ptw_fill_s exp;
        while (fill_v_o !== 1'b1 && n < 50) begin
            if (mem_req_v_o === 1'b1) extra = 1'b1;
            @(negedge clk);
            n++;
        end
        check("extra_req", extra, 0);
        if (fill_v_o !== 1'b1) begin
            check("fill_timeout", fill_v_o, 1);
            recover();
            return;
        end
        if (exp_fill_q.size() == 0) begin
            check("fill_unexpected", fill_v_o, 0);
            recover();
            return;
        end
        exp = exp_fill_q.pop_front();
        check_fill("fill", exp);
        for (int unsigned i = 0; i < hold; i++) begin
            @(negedge clk);
            check_fill("fill_hold", exp);
        end
        fill_yumi_i = 1'b1;
        @(negedge clk);
        fill_yumi_i = 1'b0;
        check("fill_released", fill_v_o, 0);
        check("idle_ready", miss_ready_o, 1);
    endtask

    initial begin
        int unsigned n;
        reset_i         = 1'b1;
        satp_ppn_i      = '0;
        miss_v_i        = 1'b0;
        miss_vpn_i      = '0;
        mem_req_ready_i = 1'b0;
        mem_resp_v_i    = 1'b0;
        mem_resp_data_i = '0;
        fill_yumi_i     = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_miss_ready", miss_ready_o, 1);
        check("rst_req_v", mem_req_v_o, 0);
        check("rst_fill_v", fill_v_o, 0);
        check("rst_req_addr", mem_req_addr_o, 0);
        check("rst_fill_ppn", fill_ppn_o, 0);
        check("rst_fill_vpn", fill_vpn_o, 0);
        reset_i = 1'b0;
        @(negedge clk);

        // 4K walk through all three levels
        exp_addr_q.push_back(56'h80000008);
        exp_addr_q.push_back(56'h80001010);
        exp_addr_q.push_back(56'h80002018);
        expect_fill(27'h40403, 44'h12345, 2'd0, 8'hCF, 1'b0);
        present_miss(44'h80000, 27'h40403);
        serve(64'h20000401, 0, 1'b0);
        serve(64'h20000801, 0, 1'b0);
        serve(64'h048D14CF, 0, 1'b0);
        finish_walk(0);

        // Gigapage leaf at the root
        exp_addr_q.push_back(56'h80000008);
        expect_fill(27'h40403, 44'h40403, 2'd2, 8'hCF, 1'b0);
        present_miss(44'h80000, 27'h40403);
        serve(64'h100000CF, 0, 1'b0);
        finish_walk(0);

        // Misaligned gigapage
        exp_addr_q.push_back(56'h80000008);
        expect_fill(27'h40403, 44'h0, 2'd2, 8'hCF, 1'b1);
        present_miss(44'h80000, 27'h40403);
        serve(64'h100004CF, 0, 1'b0);
        finish_walk(0);

        // Invalid PTE at level 1
        exp_addr_q.push_back(56'h80000008);
        exp_addr_q.push_back(56'h80001010);
        expect_fill(27'h40403, 44'h0, 2'd1, 8'h00, 1'b1);
        present_miss(44'h80000, 27'h40403);
        serve(64'h20000401, 0, 1'b0);
        serve(64'h00000000, 0, 1'b0);
        finish_walk(0);

        // Request backpressure, response coinciding with the SEND handshake, held fill
        exp_addr_q.push_back(56'h80000008);
        exp_addr_q.push_back(56'h80001010);
        exp_addr_q.push_back(56'h80002018);
        expect_fill(27'h40403, 44'h12345, 2'd0, 8'hCF, 1'b0);
        present_miss(44'h80000, 27'h40403);
        serve(64'h20000401, 5, 1'b1);
        serve(64'h20000801, 0, 1'b0);
        serve(64'h048D14CF, 0, 1'b0);
        finish_walk(4);

        // Back-to-back: second miss waiting while the fill is held
        exp_addr_q.push_back(56'h80000008);
        expect_fill(27'h40403, 44'h40403, 2'd2, 8'hCF, 1'b0);
        present_miss(44'h80000, 27'h40403);
        serve(64'h100000CF, 0, 1'b0);
        exp_addr_q.push_back(56'h90000018);
        expect_fill(27'h0C0005, 44'h40005, 2'd2, 8'hCF, 1'b0);
        miss_v_i   = 1'b1;
        satp_ppn_i = 44'h90000;
        miss_vpn_i = 27'h0C0005;
        finish_walk(2);
        check("b2b_not_yet_sent", mem_req_v_o, 0);
        @(negedge clk);
        miss_v_i   = 1'b0;
        satp_ppn_i = 44'hABCDE;
        miss_vpn_i = '0;
        check("b2b_accepted", miss_ready_o, 0);
        serve(64'h100000CF, 0, 1'b0);
        finish_walk(0);

        // Reset while a read is outstanding; the late response must be dropped
        exp_addr_q.push_back(56'h80000008);
        present_miss(44'h80000, 27'h40403);
        n = 0;
        while (mem_req_v_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rstwait_req_v", mem_req_v_o, 1);
        if (exp_addr_q.size() != 0) check("rstwait_req_addr", mem_req_addr_o, exp_addr_q.pop_front());
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        check("rstwait_in_wait", mem_req_v_o, 0);
        reset_i = 1'b1;
        #1;
        check("rstwait_miss_ready", miss_ready_o, 1);
        check("rstwait_req_v0", mem_req_v_o, 0);
        check("rstwait_fill_v0", fill_v_o, 0);
        check("rstwait_fill_ppn0", fill_ppn_o, 0);
        @(negedge clk);
        reset_i         = 1'b0;
        mem_resp_v_i    = 1'b1;
        mem_resp_data_i = 64'h100000CF;
        @(negedge clk);
        mem_resp_v_i    = 1'b0;
        mem_resp_data_i = '0;
        check("late_resp_fill_v", fill_v_o, 0);
        check("late_resp_req_v", mem_req_v_o, 0);
        check("late_resp_ready", miss_ready_o, 1);
        check("late_resp_fill_vpn", fill_vpn_o, 0);

        // Walker still works after the reset
        exp_addr_q.push_back(56'h80000008);
        expect_fill(27'h40403, 44'h40403, 2'd2, 8'hCF, 1'b0);
        present_miss(44'h80000, 27'h40403);
        serve(64'h100000CF, 0, 1'b0);
        finish_walk(0);

        check("scoreboard_empty", 64'(exp_addr_q.size() + exp_fill_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
